// File: rtl/flow_win_agg.sv
// flow_win_agg: per-flow packet window aggregator with a one-deep output slot.
// Optional IAT tracking is built when FLOW_IAT_EN is defined.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   meta_w          meta record, [143:40] is the IP 5-tuple
//   meta_v_w        meta_w / o_pkt_size valid (no backpressure)
//   o_pkt_size      packet size of the current record
//   feat_*          emitted window record, feat_v/feat_rdy handshake
//   drop_cnt        saturating count of records lost to backpressure
module flow_win_agg #(
  parameter int unsigned WIN_PKTS  = 8,
  parameter int unsigned TBL_IDX_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [143:0]   meta_w,
  input  logic           meta_v_w,
  input  logic [15:0]    o_pkt_size,
  output logic [103:0]   feat_tuple,
  output logic [23:0]    feat_size_sum,
  output logic [15:0]    feat_size_max,
  output logic [15:0]    feat_iat_max,
  output logic           feat_v,
  input  logic           feat_rdy,
  output logic [15:0]    drop_cnt
);

  localparam int unsigned DEPTH = 1 << TBL_IDX_W;
  localparam logic [7:0] WIN_CNT = 8'(WIN_PKTS);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  logic [15:0]          timer;
  logic [103:0]         tuple;
  logic [3:0]           fold;
  logic [TBL_IDX_W-1:0] idx;

  logic [DEPTH-1:0] t_vld;
  logic [103:0]     t_tag [DEPTH];
  logic [7:0]       t_cnt [DEPTH];
  logic [23:0]      t_sum [DEPTH];
  logic [15:0]      t_max [DEPTH];

  logic        hit;
  logic        emit;
  logic [24:0] sum_ext;
  logic [7:0]  n_cnt;
  logic [23:0] n_sum;
  logic [15:0] n_max;
  logic [15:0] n_imax;

  slot_e state;
  slot_e state_nx;
  logic  load;
  logic  drop;

  logic unused_meta;
  assign unused_meta = ^meta_w[39:0];

  assign tuple = meta_w[143:40];

  // fold all 26 nibbles of the tuple into one
  always_comb begin
    fold = 4'd0;
    for (int i = 0; i < 26; i++) begin
      fold = fold ^ tuple[i*4 +: 4];
    end
  end

  assign idx = TBL_IDX_W'(fold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  always_comb begin
    hit     = t_vld[idx] && (t_tag[idx] == tuple);
    sum_ext = {1'b0, t_sum[idx]}
            + {9'd0, o_pkt_size};
    n_cnt   = 8'd1;
    n_sum   = {8'd0, o_pkt_size};
    n_max   = o_pkt_size;
    if (hit) begin
      n_cnt = t_cnt[idx] + 8'd1;
      n_sum = sum_ext[24] ? 24'hFF_FFFF
                          : sum_ext[23:0];
      n_max = (o_pkt_size > t_max[idx])
            ? o_pkt_size : t_max[idx];
    end
  end

  assign emit = meta_v_w && (n_cnt == WIN_CNT);

`ifdef FLOW_IAT_EN
  logic [15:0] t_imax [DEPTH];
  logic [15:0] t_last [DEPTH];
  logic [15:0] iat;

  // 16-bit subtraction gives the wrap-around IAT
  always_comb begin
    iat    = timer - t_last[idx];
    n_imax = 16'd0;
    if (hit) begin
      n_imax = (iat > t_imax[idx])
             ? iat : t_imax[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (meta_v_w) begin
      t_imax[idx] <= n_imax;
      t_last[idx] <= timer;
    end
  end
`else
  logic unused_timer;
  assign unused_timer = ^timer;
  assign n_imax = 16'd0;
`endif

  // a completed window frees its entry at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_vld <= '0;
    end else if (meta_v_w) begin
      t_vld[idx] <= !emit;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_v_w) begin
      t_tag[idx] <= tuple;
      t_cnt[idx] <= n_cnt;
      t_sum[idx] <= n_sum;
      t_max[idx] <= n_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (emit) begin
          state_nx = S_FULL;
          load     = 1'b1;
        end
      end
      S_FULL: begin
        if (emit) begin
          if (feat_rdy) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (feat_rdy) begin
          state_nx = S_EMPTY;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  assign feat_v = (state == S_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_tuple    <= '0;
      feat_size_sum <= '0;
      feat_size_max <= '0;
    end else if (load) begin
      feat_tuple    <= tuple;
      feat_size_sum <= n_sum;
      feat_size_max <= n_max;
    end
  end

`ifdef FLOW_IAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_iat_max <= '0;
    end else if (load) begin
      feat_iat_max <= n_imax;
    end
  end
`else
  assign feat_iat_max = 16'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_flow_win_agg.sv
// tb_flow_win_agg: randomized and directed bench for flow_win_agg
// against a behavioural flow-table model.
module tb_flow_win_agg;

  localparam int WIN   = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 1 << IW;
`ifdef FLOW_IAT_EN
  localparam bit IAT_ON = 1'b1;
`else
  localparam bit IAT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] meta_w;
  logic         meta_v_w;
  logic [15:0]  o_pkt_size;
  logic [103:0] feat_tuple;
  logic [23:0]  feat_size_sum;
  logic [15:0]  feat_size_max;
  logic [15:0]  feat_iat_max;
  logic         feat_v;
  logic         feat_rdy;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  flow_win_agg #(
    .WIN_PKTS  (WIN),
    .TBL_IDX_W (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .meta_w        (meta_w),
    .meta_v_w      (meta_v_w),
    .o_pkt_size    (o_pkt_size),
    .feat_tuple    (feat_tuple),
    .feat_size_sum (feat_size_sum),
    .feat_size_max (feat_size_max),
    .feat_iat_max  (feat_iat_max),
    .feat_v        (feat_v),
    .feat_rdy      (feat_rdy),
    .drop_cnt      (drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag,
                       logic [127:0] got,
                       logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    bit           v;
    logic [103:0] tag;
    int           cnt;
    int           sum;
    int           mx;
    int           imax;
    int           last;
  } ent_t;

  ent_t         tbl [DEPTH];
  int           m_timer;
  bit           m_fv;
  logic [103:0] m_tuple;
  int           m_sum;
  int           m_mx;
  int           m_imax;
  int           m_drop;

  function automatic int hsh(logic [103:0] t);
    int h;
    h = 0;
    for (int i = 0; i < 26; i++) begin
      h = h ^ int'(t[i*4 +: 4]);
    end
    return h % DEPTH;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].v = 1'b0;
    end
    m_timer = 0;
    m_fv    = 1'b0;
    m_tuple = '0;
    m_sum   = 0;
    m_mx    = 0;
    m_imax  = 0;
    m_drop  = 0;
  endfunction

  function automatic void model_step(bit mv,
                                     logic [103:0] tp,
                                     int sz, bit rdy);
    bit   hs;
    bit   emit;
    ent_t e;
    int   i;
    int   iat;
    hs   = m_fv && rdy;
    emit = 1'b0;
    i    = hsh(tp);
    if (mv) begin
      if (tbl[i].v && tbl[i].tag == tp) begin
        tbl[i].cnt += 1;
        if (tbl[i].sum + sz > 'hFFFFFF) tbl[i].sum = 'hFFFFFF;
        else tbl[i].sum = tbl[i].sum + sz;
        if (sz > tbl[i].mx) tbl[i].mx = sz;
        iat = (m_timer - tbl[i].last) & 'hFFFF;
        if (IAT_ON && iat > tbl[i].imax) tbl[i].imax = iat;
        tbl[i].last = m_timer;
      end else begin
        tbl[i] = '{v: 1'b1, tag: tp, cnt: 1, sum: sz,
                   mx: sz, imax: 0, last: m_timer};
      end
      if (tbl[i].cnt == WIN) begin
        emit     = 1'b1;
        e        = tbl[i];
        tbl[i].v = 1'b0;
      end
    end
    if (emit) begin
      if (!m_fv || hs) begin
        m_fv    = 1'b1;
        m_tuple = e.tag;
        m_sum   = e.sum;
        m_mx    = e.mx;
        m_imax  = e.imax;
      end else if (m_drop < 'hFFFF) begin
        m_drop++;
      end
    end else if (hs) begin
      m_fv = 1'b0;
    end
    m_timer = (m_timer + 1) & 'hFFFF;
  endfunction

  task automatic check_model();
    check("feat_v", feat_v, m_fv);
    check("drop_cnt", drop_cnt, m_drop);
    if (m_fv) begin
      check("tuple", feat_tuple, m_tuple);
      check("sum", feat_size_sum, m_sum);
      check("max", feat_size_max, m_mx);
      check("iat", feat_iat_max, m_imax);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cyc(bit mv, logic [103:0] tp,
                     int sz, bit rdy);
    meta_v_w   = mv;
    meta_w     = {tp, 40'($urandom)};
    o_pkt_size = 16'(sz);
    feat_rdy   = rdy;
    model_step(mv, tp, sz, rdy);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    meta_v_w = 1'b0;
    feat_rdy = 1'b0;
    model_reset();
    #1;
    check("rst_v", feat_v, 1'b0);
    check("rst_drop", drop_cnt, 16'd0);
    check("rst_tuple", feat_tuple, 104'd0);
    check("rst_sum", feat_size_sum, 24'd0);
    check("rst_max", feat_size_max, 16'd0);
    check("rst_iat", feat_iat_max, 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [103:0] ta;
  logic [103:0] tb;
  logic [103:0] tc;
  logic [103:0] pool [5];

  initial begin
    rst        = 1'b1;
    meta_w     = '0;
    meta_v_w   = 1'b0;
    o_pkt_size = '0;
    feat_rdy   = 1'b0;
    ta = 104'h11_2233_4455_6677_8899_AABB_CCDD;
    tb = ta ^ 104'h11;
    tc = ta ^ 104'h1;
    @(negedge clk);
    do_reset();

    // eight packets, one window
    for (int k = 1; k <= 8; k++) cyc(1'b1, ta, 100 * k, 1'b1);
    check("w_v", feat_v, 1'b1);
    check("w_sum", feat_size_sum, 24'd3600);
    check("w_max", feat_size_max, 16'd800);
    check("w_iat", feat_iat_max, IAT_ON ? 16'd1 : 16'd0);
    cyc(1'b0, '0, 0, 1'b1);
    check("w_pulse", feat_v, 1'b0);

    // colliding flows thrash one entry
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, (k % 2) ? tb : ta, 10 + k, 1'b1);
      check("thr_v", feat_v, 1'b0);
    end
    check("thr_drop", drop_cnt, 16'd0);

    // backpressure: A held, C dropped
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, ta, 20, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, tc, 30, 1'b0);
    check("bp_v", feat_v, 1'b1);
    check("bp_tuple", feat_tuple, ta);
    check("bp_sum", feat_size_sum, 24'd160);
    check("bp_drop", drop_cnt, 16'd1);
    cyc(1'b0, '0, 0, 1'b1);
    check("bp_fall", feat_v, 1'b0);

    // long gap wraps the IAT
    do_reset();
    cyc(1'b1, ta, 5, 1'b1);
    for (int k = 0; k < 69999; k++) cyc(1'b0, '0, 0, 1'b1);
    for (int k = 0; k < 7; k++) cyc(1'b1, ta, 5, 1'b1);
    check("gap_v", feat_v, 1'b1);
    check("gap_iat", feat_iat_max, IAT_ON ? 16'd4464 : 16'd0);

    // reset mid-window
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, ta, 50, 1'b1);
    do_reset();
    for (int k = 1; k <= 7; k++) cyc(1'b1, ta, 10 * k, 1'b1);
    check("mr_early", feat_v, 1'b0);
    cyc(1'b1, ta, 80, 1'b1);
    check("mr_v", feat_v, 1'b1);
    check("mr_sum", feat_size_sum, 24'd360);

    // random traffic
    do_reset();
    pool[0] = ta;
    pool[1] = tb;
    pool[2] = tc;
    pool[3] = {$urandom, $urandom, $urandom, 8'($urandom)};
    pool[4] = {$urandom, $urandom, $urandom, 8'($urandom)};
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 4) != 0,
          pool[$urandom % 5],
          int'($urandom % 65536),
          ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
